param_entry: RTL

- User-input block for PID gain and command-velocity entry; writes the values that the 7-segment parameter display reads.
- Takes the DE1 push-buttons (KEY, active-low, raw) and the one-hot parameter select vector (SW[3:0]).
- Lets the user edit one decimal digit at a time, then commit.
- Outputs binary values val_p, val_i, val_d (0..999) and val_c (0..9999), plus the in-progress edit value for live display.

---
 rtl/param_entry.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/param_entry.sv
// param_entry: push-button entry of PID gains (P/I/D, 0..999) and command
// velocity (C, 0..9999), edited one BCD digit at a time and then committed.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_n[3:0]   raw active-low buttons: [0]=inc [1]=dec [2]=next digit [3]=commit
//   ui_select    one-hot parameter select: 1000=C 0100=P 0010=I 0001=D
//   val_p/i/d    committed gains, binary
//   val_c        committed command velocity, binary
//   edit_val     edit buffer, binary
//   edit_digit   cursor position, 0=ones .. 3=thousands
//   dirty        edit buffer modified since last load or commit
//   commit_pulse one-cycle strobe following a commit
module param_entry #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [15:0] DEF_P           = 16'h0100,
   parameter logic [15:0] DEF_I           = 16'h0000,
   parameter logic [15:0] DEF_D           = 16'h0000,
   parameter logic [15:0] DEF_C           = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  key_n,
   input  logic [3:0]  ui_select,
   output logic [11:0] val_p,
   output logic [11:0] val_i,
   output logic [11:0] val_d,
   output logic [15:0] val_c,
   output logic [15:0] edit_val,
   output logic [1:0]  edit_digit,
   output logic        dirty,
   output logic        commit_pulse
);

   localparam logic [3:0] SEL_C = 4'b1000;
   localparam logic [3:0] SEL_P = 4'b0100;
   localparam logic [3:0] SEL_I = 4'b0010;
   localparam logic [3:0] SEL_D = 4'b0001;

   function automatic logic [15:0] bcd4_to_bin(input logic [15:0] b);
      return 16'(b[15:12]) * 16'd1000 + 16'(b[11:8]) * 16'd100 +
             16'(b[7:4]) * 16'd10 + 16'(b[3:0]);
   endfunction

   function automatic logic [11:0] bcd3_to_bin(input logic [11:0] b);
      return 12'(b[11:8]) * 12'd100 + 12'(b[7:4]) * 12'd10 + 12'(b[3:0]);
   endfunction

   // Step one digit up or down with decimal wrap; neighbours are untouched.
   function automatic logic [15:0] bcd_bump(input logic [15:0] b,
                                            input logic [1:0]  pos,
                                            input logic        up);
      logic [15:0] r;
      logic [3:0]  d;
      r = b;
      d = b[{pos, 2'b00} +: 4];
      if (up) d = (d >= 4'd9) ? 4'd0 : d + 4'd1;
      else    d = (d == 4'd0) ? 4'd9 : d - 4'd1;
      r[{pos, 2'b00} +: 4] = d;
      return r;
   endfunction

   // ---------------- key synchronise / debounce / press detect
   logic [3:0]       sync1_q, sync2_q, deb_q, deb_d, press_q, press_d;
   logic [3:0][15:0] cnt_q, cnt_d;

   always_comb begin
      deb_d   = deb_q;
      press_d = 4'b0000;
      cnt_d   = '0;
      for (int k = 0; k < 4; k++) begin
         if (sync2_q[k] != deb_q[k]) begin
            if (cnt_q[k] == DEBOUNCE_CYCLES - 16'd1) begin
               deb_d[k]   = sync2_q[k];
               press_d[k] = ~sync2_q[k];   // only the 1->0 edge is an event
            end else begin
               cnt_d[k] = cnt_q[k] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         deb_q   <= 4'hF;
         press_q <= 4'h0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- select tracking, edit buffer, committed stores
   logic [3:0]  sel_q, selprev_q;
   logic [15:0] ebuf_q, ebuf_d, st_c_q, st_c_d;
   logic [11:0] st_p_q, st_p_d, st_i_q, st_i_d, st_d_q, st_d_d;
   logic [1:0]  digit_q, digit_d, digit_max;
   logic        dirty_q, dirty_d, pulse_q, pulse_d, sel_valid;

   always_comb begin
      case (sel_q)
         SEL_C, SEL_P, SEL_I, SEL_D: sel_valid = 1'b1;
         default:                    sel_valid = 1'b0;
      endcase
   end

   // C has four editable digits, the gains only three.
   assign digit_max = (sel_q == SEL_C) ? 2'd3 : 2'd2;

   always_comb begin
      ebuf_d  = ebuf_q;
      digit_d = digit_q;
      dirty_d = dirty_q;
      pulse_d = 1'b0;
      st_c_d  = st_c_q;
      st_p_d  = st_p_q;
      st_i_d  = st_i_q;
      st_d_d  = st_d_q;
      if (!sel_valid) begin
         digit_d = 2'd0;
      end else if (sel_q != selprev_q) begin
         // A new selection reloads the buffer, dropping any pending edit and
         // any event arriving in the same cycle.
         case (sel_q)
            SEL_C:   ebuf_d = st_c_q;
            SEL_P:   ebuf_d = {4'h0, st_p_q};
            SEL_I:   ebuf_d = {4'h0, st_i_q};
            SEL_D:   ebuf_d = {4'h0, st_d_q};
            default: ebuf_d = ebuf_q;
         endcase
         digit_d = 2'd0;
         dirty_d = 1'b0;
      end else if (press_q[3]) begin
         case (sel_q)
            SEL_C:   st_c_d = ebuf_q;
            SEL_P:   st_p_d = ebuf_q[11:0];
            SEL_I:   st_i_d = ebuf_q[11:0];
            SEL_D:   st_d_d = ebuf_q[11:0];
            default: ;
         endcase
         pulse_d = 1'b1;
         dirty_d = 1'b0;
      end else if (press_q[2]) begin
         digit_d = (digit_q == digit_max) ? 2'd0 : digit_q + 2'd1;
      end else if (press_q[0]) begin
         ebuf_d  = bcd_bump(ebuf_q, digit_q, 1'b1);
         dirty_d = 1'b1;
      end else if (press_q[1]) begin
         ebuf_d  = bcd_bump(ebuf_q, digit_q, 1'b0);
         dirty_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= 4'h0;
         selprev_q <= 4'h0;
         ebuf_q    <= 16'h0000;
         digit_q   <= 2'd0;
         dirty_q   <= 1'b0;
         pulse_q   <= 1'b0;
         st_c_q    <= DEF_C;
         st_p_q    <= DEF_P[11:0];
         st_i_q    <= DEF_I[11:0];
         st_d_q    <= DEF_D[11:0];
      end else begin
         sel_q     <= ui_select;
         selprev_q <= sel_q;
         ebuf_q    <= ebuf_d;
         digit_q   <= digit_d;
         dirty_q   <= dirty_d;
         pulse_q   <= pulse_d;
         st_c_q    <= st_c_d;
         st_p_q    <= st_p_d;
         st_i_q    <= st_i_d;
         st_d_q    <= st_d_d;
      end
   end

   assign val_p        = bcd3_to_bin(st_p_q);
   assign val_i        = bcd3_to_bin(st_i_q);
   assign val_d        = bcd3_to_bin(st_d_q);
   assign val_c        = bcd4_to_bin(st_c_q);
   assign edit_val     = bcd4_to_bin(ebuf_q);
   assign edit_digit   = digit_q;
   assign dirty        = dirty_q;
   assign commit_pulse = pulse_q;

endmodule
